// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling and the IF/ID
// pipeline register, sequenced by a small BOOT/RUN/WAIT/HALT controller.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        PCSrc,
   input  logic [1:0]  J,
   input  logic [31:0] PCTarget,
   input  logic [31:0] ALUResult,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_rdata,
   input  logic        instr_ready,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct75,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic [31:0] pcp4d_q, pcp4d_d;
   logic        valid_q, valid_d;
   logic [31:0] fcnt_q, fcnt_d;

   logic        redirect;
   logic        ebreak_seen;
   logic [31:0] target, pc_plus4;

   assign ebreak_seen = valid_q && (instr_q == EBREAK);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_BOOT;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (ebreak_seen)                     state_d = S_HALT;
            else if (!instr_ready && !redirect)  state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ebreak_seen)                     state_d = S_HALT;
            else if (instr_ready || redirect)    state_d = S_RUN;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
   end

   // FSM: outputs
   always_comb begin
      halted   = (state_q == S_HALT);
      redirect = PCSrc && ((state_q == S_RUN) || (state_q == S_WAIT));
   end

   // Low two target bits are dropped so the PC can never leave word alignment.
   always_comb begin
      target   = (J == 2'b10) ? ALUResult : PCTarget;
      target   = {target[31:2], 2'b00};
      pc_plus4 = pc_q + 32'd4;

      if (halted)           pc_d = pc_q;
      else if (redirect)    pc_d = target;
      else if (stall)       pc_d = pc_q;
      else if (instr_ready) pc_d = pc_plus4;
      else                  pc_d = pc_q;
   end

   // Bubbles keep PCD/PCPlus4D of the last real instruction; only ValidD marks them.
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4d_d = pcp4d_q;
      valid_d = valid_q;
      if (flush || redirect || halted) begin
         instr_d = NOP;
         valid_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else if (instr_ready) begin
         instr_d = instr_rdata;
         pcd_d   = pc_q;
         pcp4d_d = pc_plus4;
         valid_d = 1'b1;
      end else begin
         instr_d = NOP;
         valid_d = 1'b0;
      end
      fcnt_d = fcnt_q + {31'd0, (valid_d && !(stall && !(flush || redirect || halted)))};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pcd_q   <= RESET_PC;
         pcp4d_q <= RESET_PC + 32'd4;
         valid_q <= 1'b0;
         fcnt_q  <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         pcp4d_q <= pcp4d_d;
         valid_q <= valid_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign instr_addr  = pc_q;
   assign InstrD      = instr_q;
   assign PCD         = pcd_q;
   assign PCPlus4D    = pcp4d_q;
   assign ValidD      = valid_q;
   assign fetch_count = fcnt_q;
   assign op          = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct75     = instr_q[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addi x1,x0,<addr> words,
// optionally an EBREAK at one address; every expectation is hand-computed.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, PCSrc, instr_ready;
   logic [1:0]  J;
   logic [31:0] PCTarget, ALUResult, instr_rdata;
   logic [31:0] instr_addr, InstrD, PCD, PCPlus4D, fetch_count;
   logic        ValidD, funct75, halted;
   logic [6:0]  op;
   logic [2:0]  funct3;

   logic        ebrk_en;
   logic [31:0] ebrk_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .PCSrc(PCSrc), .J(J),
      .PCTarget(PCTarget), .ALUResult(ALUResult), .instr_addr(instr_addr),
      .instr_rdata(instr_rdata), .instr_ready(instr_ready), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD), .op(op), .funct3(funct3), .funct75(funct75),
      .halted(halted), .fetch_count(fetch_count)
   );

   always_comb begin
      if (ebrk_en && instr_addr == ebrk_addr) instr_rdata = 32'h0010_0073;
      else                                     instr_rdata = {instr_addr[11:0], 20'h00093};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic [31:0] addr, input logic vld,
                         input logic [31:0] ins, input logic [31:0] pcd, input logic [31:0] fc);
      chk({tag, ".addr"},  instr_addr,  addr);
      chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, vld});
      chk({tag, ".instr"}, InstrD,      ins);
      chk({tag, ".pcd"},   PCD,         pcd);
      chk({tag, ".fcnt"},  fetch_count, fc);
   endtask

   initial begin
      rst_n = 0; stall = 0; flush = 0; PCSrc = 0; J = 2'b00;
      PCTarget = 0; ALUResult = 0; instr_ready = 1; ebrk_en = 0; ebrk_addr = 0;
      step(); step();
      chk_if("reset", 32'h0, 0, 32'h13, 32'h0, 32'h0);
      chk("reset.pcp4", PCPlus4D, 32'h4);
      chk("reset.halted", {31'd0, halted}, 32'd0);

      // BOOT cycle shows the bubble; then sequential fetch
      rst_n = 1;
      chk("boot.valid", {31'd0, ValidD}, 32'd0);
      step(); chk_if("seq0", 32'h4,  1, 32'h0000_0093, 32'h0, 32'd1);
      chk("seq0.pcp4", PCPlus4D, 32'h4);
      step(); chk_if("seq1", 32'h8,  1, 32'h0040_0093, 32'h4, 32'd2);
      step(); chk_if("seq2", 32'hC,  1, 32'h0080_0093, 32'h8, 32'd3);
      step(); chk_if("seq3", 32'h10, 1, 32'h00C0_0093, 32'hC, 32'd4);

      // branch redirect from PC=0x10
      PCSrc = 1; J = 2'b00; PCTarget = 32'h80;
      step(); chk_if("br", 32'h80, 0, 32'h13, 32'hC, 32'd4);
      PCSrc = 0;
      step(); chk_if("br.next", 32'h84, 1, 32'h0800_0093, 32'h80, 32'd5);

      // JAL to misaligned target: low bits dropped
      PCSrc = 1; J = 2'b01; PCTarget = 32'h4B;
      step(); chk_if("jal", 32'h48, 0, 32'h13, 32'h80, 32'd5);
      PCSrc = 0;

      // JALR with simultaneous stall: redirect wins
      PCSrc = 1; J = 2'b10; ALUResult = 32'h103; PCTarget = 32'h200; stall = 1;
      step(); chk_if("jalr", 32'h100, 0, 32'h13, 32'h80, 32'd5);
      PCSrc = 0; stall = 0;
      step(); chk_if("jalr.next", 32'h104, 1, 32'h1000_0093, 32'h100, 32'd6);

      // three stall cycles, flush on the last
      stall = 1;
      step(); chk_if("stall1", 32'h104, 1, 32'h1000_0093, 32'h100, 32'd6);
      step(); chk_if("stall2", 32'h104, 1, 32'h1000_0093, 32'h100, 32'd6);
      flush = 1;
      step(); chk_if("stall3f", 32'h104, 0, 32'h13, 32'h100, 32'd6);
      stall = 0; flush = 0;

      // memory not ready for two cycles, then resume at same PC
      instr_ready = 0;
      step(); chk_if("wait1", 32'h104, 0, 32'h13, 32'h100, 32'd6);
      step(); chk_if("wait2", 32'h104, 0, 32'h13, 32'h100, 32'd6);
      instr_ready = 1;
      step(); chk_if("resume", 32'h108, 1, 32'h1040_0093, 32'h104, 32'd7);

      // PC+4 wraps past the top of the address space
      PCSrc = 1; J = 2'b01; PCTarget = 32'hFFFF_FFFC;
      step(); chk("wrap.addr", instr_addr, 32'hFFFF_FFFC);
      PCSrc = 0;
      step(); chk_if("wrap", 32'h0, 1, 32'hFFC0_0093, 32'hFFFF_FFFC, 32'd8);
      chk("wrap.pcp4", PCPlus4D, 32'h0);
      chk("wrap.op", {25'd0, op}, 32'h13);
      chk("wrap.f3", {29'd0, funct3}, 32'h0);
      chk("wrap.f75", {31'd0, funct75}, 32'd1);

      // EBREAK at 0x4 halts the stage
      ebrk_en = 1; ebrk_addr = 32'h4;
      step(); chk_if("pre.ebrk", 32'h4, 1, 32'h0000_0093, 32'h0, 32'd9);
      step(); chk_if("ebrk", 32'h8, 1, 32'h0010_0073, 32'h4, 32'd10);
      chk("ebrk.halted", {31'd0, halted}, 32'd0);
      chk("ebrk.op", {25'd0, op}, 32'h73);
      chk("ebrk.f75", {31'd0, funct75}, 32'd0);
      step(); chk("halt.halted", {31'd0, halted}, 32'd1);
      chk_if("halt", 32'hC, 1, 32'h0080_0093, 32'h8, 32'd11);
      PCSrc = 1; J = 2'b00; PCTarget = 32'h40;
      step(); chk_if("halt.hold", 32'hC, 0, 32'h13, 32'h8, 32'd11);
      chk("halt.hold.halted", {31'd0, halted}, 32'd1);
      step(); chk_if("halt.hold2", 32'hC, 0, 32'h13, 32'h8, 32'd11);
      PCSrc = 0;

      // reset out of HALT
      rst_n = 0;
      step(); chk_if("rst2", 32'h0, 0, 32'h13, 32'h0, 32'd0);
      chk("rst2.pcp4", PCPlus4D, 32'h4);
      chk("rst2.halted", {31'd0, halted}, 32'd0);
      rst_n = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
